// File: rtl/hour_display_scanner_if.sv
// hour_display_scanner_if: digit/control inputs and pin-side outputs of the display scanner
// Signals:
//   bcd_in      packed BCD digits, hour pair in the top two slots
//   mode_12h    show hours in 12h format
//   blank_lz    blank a zero hour-tens digit
//   blink_en    per-digit blink enable
//   seg         segment bus {a,b,c,d,e,f,g}
//   an          anode select
//   pm          PM indicator (12h mode only)
//   frame_start one-cycle pulse when digit 0 is selected
// master = timekeeping/set-mode side, slave = scanner.
interface hour_display_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic                    mode_12h;
    logic                    blank_lz;
    logic [NUM_DIGITS-1:0]   blink_en;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   an;
    logic                    pm;
    logic                    frame_start;

    modport master (
        output bcd_in, mode_12h, blank_lz, blink_en,
        input  seg, an, pm, frame_start
    );

    modport slave (
        input  bcd_in, mode_12h, blank_lz, blink_en,
        output seg, an, pm, frame_start
    );
endinterface

// File: rtl/hour_display_scanner.sv
// hour_display_scanner: time-multiplexed 7-segment driver for an HH:MM(:SS) clock display
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    hour_display_scanner_if.slave (bcd_in, mode_12h, blank_lz, blink_en in;
//          seg, an, pm, frame_start out, all outputs registered)
// One digit is selected per refresh tick. Inputs are snapshotted when the scan wraps to
// digit 0 so a frame never mixes old and new values; blink_en is used live.
module hour_display_scanner #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter int BLINK_DIV      = 250,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input logic                   clk,
    input logic                   reset,
    hour_display_scanner_if.slave bus
);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_ACTIVE_LOW}};
    localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx, nidx;
    logic [BW-1:0]           bcnt;
    logic                    phase;
    logic [4*NUM_DIGITS-1:0] snap_bcd, src_bcd;
    logic                    snap_12h, snap_blz, src_12h, src_blz;
    logic                    tick, wrap;
    logic [3:0]              ht, hu, dt, du, nib;
    logic                    h_valid, is_pm, h_zero, teen;
    logic                    hr_tens, hr_units, lz, blink_off;
    logic [6:0]              dec, seg_raw;
    logic [NUM_DIGITS-1:0]   onehot;

    always_comb begin
        tick      = cnt == CW'(REFRESH_DIV - 1);
        wrap      = idx == IW'(NUM_DIGITS - 1);
        nidx      = wrap ? '0 : idx + IW'(1);
        // The slot selected on a wrapping tick must already see the new snapshot.
        src_bcd   = wrap ? bus.bcd_in : snap_bcd;
        src_12h   = wrap ? bus.mode_12h : snap_12h;
        src_blz   = wrap ? bus.blank_lz : snap_blz;
        ht        = src_bcd[4*NUM_DIGITS-1 -: 4];
        hu        = src_bcd[4*NUM_DIGITS-5 -: 4];
        h_valid   = ht <= 4'd2 && hu <= 4'd9 && !(ht == 4'd2 && hu > 4'd3);
        is_pm     = ht == 4'd2 || (ht == 4'd1 && hu >= 4'd2);
        h_zero    = ht == 4'd0 && hu == 4'd0;
        teen      = ht == 4'd1 && hu >= 4'd3;
        // BCD-domain 12h mapping: 00->12, 13-19->01-07, 20-21->08-09, 22-23->10-11.
        dt        = !src_12h ? ht : h_zero ? 4'd1 : teen ? 4'd0 :
                    ht == 4'd2 ? (hu < 4'd2 ? 4'd0 : 4'd1) : ht;
        du        = !src_12h ? hu : h_zero ? 4'd2 : teen ? hu - 4'd2 :
                    ht == 4'd2 ? (hu < 4'd2 ? hu + 4'd8 : hu - 4'd2) : hu;
        hr_tens   = nidx == IW'(NUM_DIGITS - 1);
        hr_units  = nidx == IW'(NUM_DIGITS - 2);
        nib       = hr_tens ? dt : hr_units ? du : src_bcd[{nidx, 2'b00} +: 4];
        case (nib)
            4'd0:    dec = 7'b1111110;
            4'd1:    dec = 7'b0110000;
            4'd2:    dec = 7'b1101101;
            4'd3:    dec = 7'b1111001;
            4'd4:    dec = 7'b0110011;
            4'd5:    dec = 7'b1011011;
            4'd6:    dec = 7'b1011111;
            4'd7:    dec = 7'b1110000;
            4'd8:    dec = 7'b1111111;
            4'd9:    dec = 7'b1111011;
            default: dec = 7'b0000001;
        endcase
        lz        = src_blz && h_valid && hr_tens && dt == 4'd0;
        blink_off = phase && bus.blink_en[nidx];
        seg_raw   = (blink_off || lz) ? 7'd0 :
                    ((hr_tens || hr_units) && !h_valid) ? 7'b0000001 : dec;
        onehot    = blink_off ? '0 : NUM_DIGITS'(1) << nidx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt             <= '0;
            idx             <= IW'(NUM_DIGITS - 1);
            bcnt            <= '0;
            phase           <= 1'b0;
            snap_bcd        <= '0;
            snap_12h        <= 1'b0;
            snap_blz        <= 1'b0;
            bus.an          <= AN_OFF;
            bus.seg         <= SEG_OFF;
            bus.pm          <= 1'b0;
            bus.frame_start <= 1'b0;
        end else begin
            cnt             <= tick ? '0 : cnt + CW'(1);
            bus.frame_start <= tick && wrap;
            if (tick) begin
                idx     <= nidx;
                bcnt    <= bcnt == BW'(BLINK_DIV - 1) ? '0 : bcnt + BW'(1);
                phase   <= bcnt == BW'(BLINK_DIV - 1) ? !phase : phase;
                bus.an  <= AN_ACTIVE_LOW ? ~onehot : onehot;
                bus.seg <= SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
                bus.pm  <= src_12h && h_valid && is_pm;
                if (wrap) begin
                    snap_bcd <= bus.bcd_in;
                    snap_12h <= bus.mode_12h;
                    snap_blz <= bus.blank_lz;
                end
            end
        end
    end
endmodule

// File: doc/hour_display_scanner.md
Name: hour_display_scanner

Overview:
- Parametrised, time-multiplexed seven-segment driver for the clock's HH:MM(:SS) display.
- Takes packed BCD digits, with the hour pair in the two most-significant digit slots.
- Performs 24h-to-12h conversion with an AM/PM flag, leading-zero blanking, per-digit blink and invalid-digit dash display.
- Scans one digit per refresh tick through a shared segment bus; sits between the timekeeping/set-mode logic and the board's anode/cathode pins.

Parameters:
- NUM_DIGITS, 4, number of display digits (>=2); digits NUM_DIGITS-1 and NUM_DIGITS-2 are hour tens and hour units.
- REFRESH_DIV, 100000, clk cycles per refresh tick (>=2).
- BLINK_DIV, 250, refresh ticks per blink phase toggle (>=1).
- SEG_ACTIVE_LOW, 1, 1 means a segment is lit when its bit is 0.
- AN_ACTIVE_LOW, 1, 1 means the selected anode is driven 0.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- bcd_in  in  4*NUM_DIGITS  packed BCD; digit i = bcd_in[4i+3:4i]; hour digits in hours 00-23
- mode_12h  in  1  1 = show hours in 12h format
- blank_lz  in  1  1 = blank hour-tens digit when it is 0 after conversion
- blink_en  in  NUM_DIGITS  per-digit blink enable
- seg  out  7  {a,b,c,d,e,f,g}, registered
- an  out  NUM_DIGITS  one-hot anode select, registered
- pm  out  1  1 = PM (valid only when mode_12h=1, else 0), registered
- frame_start  out  1  one-cycle pulse when digit 0 is selected and inputs are snapshotted

Behaviour:
- Reset: refresh counter=0, digit_idx=NUM_DIGITS-1, blink counter=0, blink_phase=0, snapshot=0, an=all inactive, seg=all off, pm=0, frame_start=0.
- refresh_tick: asserted for one cycle when the refresh counter reaches REFRESH_DIV-1; the counter then wraps to 0.
- On each tick, digit_idx increments and wraps from NUM_DIGITS-1 to 0.
- When digit_idx wraps to 0:
  - bcd_in, mode_12h and blank_lz are latched into the snapshot.
  - frame_start pulses in the same cycle the outputs update.
  - No mid-frame tearing occurs; input changes appear only at the next frame.
- Output latency: an, seg and pm update on the clock edge of the tick that selects the digit, so they are valid one cycle after the tick is sampled. They hold until the next tick.
- 12h conversion (snapshot hour H):
  - 00 -> 12, pm=0
  - 01-11 -> unchanged, pm=0
  - 12 -> 12, pm=1
  - 13-23 -> H-12, pm=1
  - The result is in BCD; binary subtraction of 0x12 is not acceptable.
- 24h mode: hour is passed through unchanged and pm=0.
- Invalid hour (either nibble >9, or value >0x23):
  - Both hour digits show a dash (g only) and pm=0.
  - Other digits are decoded independently.
- Any non-hour nibble >9 shows a dash.
- Decode 0-9, active-high sense before polarity:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011
  - Inverted when SEG_ACTIVE_LOW=1.
- Leading-zero blank: if the snapshot blank_lz=1, the displayed hour is valid and the hour-tens digit equals 0, then seg=all off and the anode is still driven for that slot.
- Blink:
  - The blink counter advances on refresh ticks and toggles blink_phase every BLINK_DIV ticks.
  - While blink_phase=1, any digit with blink_en[i]=1 has its anode deasserted for its slot; seg value is don't-care but driven all off.
  - blink_en is sampled live, not snapshotted, so set-mode response is immediate.
- Exactly one anode is active at a time, except blanked-by-blink slots (none active) and post-reset (none until first tick).
- Reset asserted mid-frame returns everything to reset values on the next edge; the first tick after reset selects digit 0 and snapshots.

Test Plan:
- REFRESH_DIV=4, NUM_DIGITS=4, mode_12h=0, bcd_in=0x2359 -> after reset, an inactive for 4 cycles; then digits 0,1,2,3 selected every 4 cycles showing 9,5,3,2; frame_start pulses with digit 0; pm=0.
- mode_12h=1, sweep hour 0x00..0x23 over frames -> displayed hour 12,01..11,12,01..11; pm=0 for 00-11 and 1 for 12-23; specifically 0x21 -> "09" PM and 0x22 -> "10" PM.
- mode_12h=1, blank_lz=1, hour=0x07 -> hour-tens slot seg=all off with anode active, units shows 7; hour=0x10 -> tens shows 1.
- hour=0x2A, and minute nibble 0xF -> both hour digits and that minute digit show dash (active-low 1111110); pm=0.
- BLINK_DIV=2, blink_en=4'b1100 -> hour anodes suppressed on alternate 2-tick phases, minute digits unaffected; blink_en cleared mid-phase -> hour anodes resume at the next slot.
- Change bcd_in mid-frame, then assert reset mid-frame -> no change is shown until the next frame_start; reset drives an inactive, seg off, pm 0, and the first post-reset tick selects digit 0.
